req_ack_responder: RTL and testbench

Handshake responder that sits directly downstream of the requester and drives the `ack` line that the req/ack implication checkers observe. Accepts single-cycle `req` pulses, queues up to `MAX_PEND` outstanding requests, and returns exactly one `ack` pulse per accepted request after a programmable latency. A `stall` input can hold back acknowledgement. Sticky overflow reporting covers requests dropped because the queue is full.

---
 rtl/req_ack_responder.sv | 160 ++++++++++++++++
 tb/tb_req_ack_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/req_ack_responder.sv
// req_ack_responder
//
// Handshake responder placed directly downstream of a requester. Each
// accepted single-cycle req pulse is answered by exactly one ack pulse after
// LATENCY cycles. Up to MAX_PEND requests may be outstanding. A request that
// arrives while the queue is full, and no ack is retiring, is dropped and
// sets the sticky overflow flag.
//
// Handshake: req is sampled every rising edge and each high cycle is one
// request. It is accepted when pending < MAX_PEND, or when an ack retires in
// the same cycle. ack is a one-cycle pulse driven combinationally from the
// ACK state and is held back while stall is high. stall has no effect
// outside ACK.
//
// Parameters:
//   LATENCY  - cycles from an isolated accepted req to its ack (1..15)
//   MAX_PEND - maximum outstanding requests (1..15)
//   CW       - width of pending (derived, do not override)
//
// Ports:
//   clk      - clock, all state on the rising edge
//   rst_n    - asynchronous active-low reset
//   req      - request input
//   stall    - suppresses ack while high
//   ack      - acknowledge pulse, one per accepted request
//   pending  - count of accepted but not yet acknowledged requests
//   busy     - high whenever the FSM is not IDLE
//   overflow - sticky, set when a request is dropped
//
// Build option:
//   REQ_ACK_RESP_SVA_EN - compiles in embedded concurrent assertions.
module req_ack_responder #(
    parameter int LATENCY  = 1,
    parameter int MAX_PEND = 4,
    parameter int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          stall,
    output logic          ack,
    output logic [CW-1:0] pending,
    output logic          busy,
    output logic          overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [CW-1:0] MAX_P = CW'(MAX_PEND);
    localparam logic [CW-1:0] ONE_P = CW'(1);
    // Two cycles of the latency are spent entering WAIT and leaving it for
    // ACK, so the countdown starts at LATENCY-2.
    localparam logic [3:0] TIMER_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]    state, state_nx;
    logic [3:0]    timer, timer_nx;
    logic [CW-1:0] pending_nx;
    logic          accept, drop, start_svc;

    assign ack    = (state == ST_ACK) && !stall;
    // A retiring ack frees a slot in the same cycle, so a full queue can
    // still take a request when ack fires.
    assign accept = req && ((pending < MAX_P) || ack);
    assign drop   = req && !accept;
    assign busy   = (state != ST_IDLE);

    always_comb begin
        pending_nx = pending;
        if (accept && !ack) begin
            pending_nx = pending + ONE_P;
        end else if (!accept && ack) begin
            pending_nx = pending - ONE_P;
        end
    end

    // Another service follows when work remains after the current one:
    // in IDLE any accepted or queued request, in ACK a request beyond the
    // one being acknowledged now.
    always_comb begin
        start_svc = 1'b0;
        case (state)
            ST_IDLE: start_svc = accept || (pending != '0);
            ST_ACK:  start_svc = accept || (pending > ONE_P);
            default: start_svc = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        case (state)
            ST_IDLE: begin
                if (start_svc) begin
                    if (LATENCY == 1) begin
                        state_nx = ST_ACK;
                    end else begin
                        state_nx = ST_WAIT;
                        timer_nx = TIMER_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (timer == 4'd0) begin
                    state_nx = ST_ACK;
                end else begin
                    timer_nx = timer - 4'd1;
                end
            end
            ST_ACK: begin
                if (!stall) begin
                    if (start_svc) begin
                        if (LATENCY == 1) begin
                            state_nx = ST_ACK;
                        end else begin
                            state_nx = ST_WAIT;
                            timer_nx = TIMER_LOAD;
                        end
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                timer_nx = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            timer    <= 4'd0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            pending  <= pending_nx;
            overflow <= overflow | drop;
        end
    end

`ifdef REQ_ACK_RESP_SVA_EN
    a_ack_has_pending: assert property (@(posedge clk) disable iff (!rst_n)
        ack |-> (pending > '0));
    a_pending_bound: assert property (@(posedge clk) disable iff (!rst_n)
        pending <= MAX_P);
    a_overflow_cause: assert property (@(posedge clk) disable iff (!rst_n)
        $rose(overflow) |-> $past(drop));
    a_overflow_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        overflow |=> overflow);
    a_ack_in_ack_state: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ST_ACK && !stall) |-> ack);
`else
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Testbench for req_ack_responder. Four instances cover the LATENCY/MAX_PEND
// configurations of interest; they share clock and reset, and each has its
// own req/stall. Inputs are driven just after the falling edge and outputs
// are sampled 1ns later, so every sample shows the registered state of that
// cycle together with the combinational ack.
module tb_req_ack_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // LATENCY=1, MAX_PEND=4
    logic       req1 = 1'b0, stall1 = 1'b0, ack1, busy1, ovf1;
    logic [2:0] pend1;
    // LATENCY=3, MAX_PEND=4
    logic       req3 = 1'b0, stall3 = 1'b0, ack3, busy3, ovf3;
    logic [2:0] pend3;
    // LATENCY=2, MAX_PEND=2
    logic       req2 = 1'b0, stall2 = 1'b0, ack2, busy2, ovf2;
    logic [1:0] pend2;
    // LATENCY=4, MAX_PEND=4
    logic       req4 = 1'b0, stall4 = 1'b0, ack4, busy4, ovf4;
    logic [2:0] pend4;

    req_ack_responder #(.LATENCY(1), .MAX_PEND(4)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .stall(stall1),
        .ack(ack1), .pending(pend1), .busy(busy1), .overflow(ovf1));
    req_ack_responder #(.LATENCY(3), .MAX_PEND(4)) u_l3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .stall(stall3),
        .ack(ack3), .pending(pend3), .busy(busy3), .overflow(ovf3));
    req_ack_responder #(.LATENCY(2), .MAX_PEND(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .stall(stall2),
        .ack(ack2), .pending(pend2), .busy(busy2), .overflow(ovf2));
    req_ack_responder #(.LATENCY(4), .MAX_PEND(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .stall(stall4),
        .ack(ack4), .pending(pend4), .busy(busy4), .overflow(ovf4));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        logic       req;
        logic       stall;
        logic       ack;
        logic [2:0] pending;
        logic       busy;
        logic       overflow;
    } vec_t;

    vec_t vecs[27];

    int exp_pend_a[11];
    int exp_pend_b[12];
    int ack_count;

    initial begin
        // {req, stall, ack, pending, busy, overflow} for the LATENCY=1 unit
        // isolated request
        vecs[0]  = '{0, 0, 0, 3'd0, 0, 0};
        vecs[1]  = '{1, 0, 0, 3'd0, 0, 0};
        vecs[2]  = '{0, 0, 1, 3'd1, 1, 0};
        vecs[3]  = '{0, 0, 0, 3'd0, 0, 0};
        // request followed by three stall cycles
        vecs[4]  = '{1, 0, 0, 3'd0, 0, 0};
        vecs[5]  = '{0, 1, 0, 3'd1, 1, 0};
        vecs[6]  = '{0, 1, 0, 3'd1, 1, 0};
        vecs[7]  = '{0, 1, 0, 3'd1, 1, 0};
        vecs[8]  = '{0, 0, 1, 3'd1, 1, 0};
        vecs[9]  = '{0, 0, 0, 3'd0, 0, 0};
        // back-to-back requests: ack every cycle, pending steady at 1
        vecs[10] = '{1, 0, 0, 3'd0, 0, 0};
        vecs[11] = '{1, 0, 1, 3'd1, 1, 0};
        vecs[12] = '{1, 0, 1, 3'd1, 1, 0};
        vecs[13] = '{1, 0, 1, 3'd1, 1, 0};
        vecs[14] = '{0, 0, 1, 3'd1, 1, 0};
        vecs[15] = '{0, 0, 0, 3'd0, 0, 0};
        // fill to MAX_PEND under stall, drop one, then req+ack while full
        vecs[16] = '{1, 0, 0, 3'd0, 0, 0};
        vecs[17] = '{1, 1, 0, 3'd1, 1, 0};
        vecs[18] = '{1, 1, 0, 3'd2, 1, 0};
        vecs[19] = '{1, 1, 0, 3'd3, 1, 0};
        vecs[20] = '{1, 1, 0, 3'd4, 1, 0};
        vecs[21] = '{1, 0, 1, 3'd4, 1, 1};
        vecs[22] = '{0, 0, 1, 3'd4, 1, 1};
        vecs[23] = '{0, 0, 1, 3'd3, 1, 1};
        vecs[24] = '{0, 0, 1, 3'd2, 1, 1};
        vecs[25] = '{0, 0, 1, 3'd1, 1, 1};
        vecs[26] = '{0, 0, 0, 3'd0, 0, 1};

        exp_pend_a = '{0, 1, 2, 3, 2, 2, 2, 1, 1, 1, 0};
        exp_pend_b = '{0, 1, 2, 2, 2, 2, 2, 1, 1, 0, 0, 0};

        // reset state, checked while reset is still asserted
        #12;
        check("rst_ack", int'(ack1), 0);
        check("rst_pending", int'(pend1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_overflow", int'(ovf1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors on the LATENCY=1 unit
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            req1   = vecs[i].req;
            stall1 = vecs[i].stall;
            #1;
            check($sformatf("v%0d_ack", i), int'(ack1), int'(vecs[i].ack));
            check($sformatf("v%0d_pending", i), int'(pend1), int'(vecs[i].pending));
            check($sformatf("v%0d_busy", i), int'(busy1), int'(vecs[i].busy));
            check($sformatf("v%0d_overflow", i), int'(ovf1), int'(vecs[i].overflow));
        end
        req1 = 1'b0;
        stall1 = 1'b0;

        // LATENCY=3: three queued requests acked every three cycles
        for (int rel = 0; rel < 11; rel++) begin
            @(negedge clk);
            req3 = (rel < 3);
            #1;
            check($sformatf("l3_ack_r%0d", rel), int'(ack3),
                  int'(rel == 3 || rel == 6 || rel == 9));
            check($sformatf("l3_pending_r%0d", rel), int'(pend3), exp_pend_a[rel]);
            check($sformatf("l3_busy_r%0d", rel), int'(busy3), int'(rel >= 1 && rel <= 9));
        end
        req3 = 1'b0;

        // LATENCY=2, MAX_PEND=2: five requests, one dropped
        ack_count = 0;
        for (int rel = 0; rel < 12; rel++) begin
            @(negedge clk);
            req2 = (rel < 5);
            #1;
            if (ack2) ack_count++;
            check($sformatf("l2_ack_r%0d", rel), int'(ack2),
                  int'(rel == 2 || rel == 4 || rel == 6 || rel == 8));
            check($sformatf("l2_pending_r%0d", rel), int'(pend2), exp_pend_b[rel]);
            check($sformatf("l2_overflow_r%0d", rel), int'(ovf2), int'(rel >= 4));
        end
        req2 = 1'b0;
        check("l2_ack_total", ack_count, 4);

        // LATENCY=4: reset asserted mid-service discards the request
        @(negedge clk);
        req4 = 1'b1;
        #1;
        check("l4_busy_r0", int'(busy4), 0);
        @(negedge clk);
        req4 = 1'b0;
        #1;
        check("l4_pending_r1", int'(pend4), 1);
        check("l4_busy_r1", int'(busy4), 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("l4_rst_ack", int'(ack4), 0);
        check("l4_rst_pending", int'(pend4), 0);
        check("l4_rst_busy", int'(busy4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int rel = 0; rel < 8; rel++) begin
            @(negedge clk);
            #1;
            check($sformatf("l4_post_ack_r%0d", rel), int'(ack4), 0);
            check($sformatf("l4_post_pending_r%0d", rel), int'(pend4), 0);
        end
        // service resumes normally after reset
        for (int rel = 0; rel < 6; rel++) begin
            @(negedge clk);
            req4 = (rel == 0);
            #1;
            check($sformatf("l4_new_ack_r%0d", rel), int'(ack4), int'(rel == 4));
        end
        req4 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
